// File: rtl/seg_capture_pkg.sv
// seg_capture_pkg
//   Shared constants for the 7-segment display capture block:
//   - SEG_0..SEG_F, SEG_BLANK : active-high segment patterns, bit0=a .. bit6=g
//   - NUM_DIGITS              : number of multiplexed digit positions
//   - frame_state_e           : frame assembly FSM states
package seg_capture_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        COLLECT = 1'b0,
        PUBLISH = 1'b1
    } frame_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode
//   Combinational reverse decoder for a 7-segment pattern.
//   Ports:
//     pattern_i  [6:0]  active-high segments, bit0=a .. bit6=g
//     value_o    [3:0]  hex value when is_valid_o=1, else 0
//     is_blank_o        all segments off
//     is_valid_o        pattern is one of the 16 hex glyphs
module seg7_pattern_decode
    import seg_capture_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] value_o,
    output logic       is_blank_o,
    output logic       is_valid_o
);

    always_comb begin
        value_o    = '0;
        is_blank_o = 1'b0;
        is_valid_o = 1'b1;
        case (pattern_i)
            SEG_0:     value_o = 4'h0;
            SEG_1:     value_o = 4'h1;
            SEG_2:     value_o = 4'h2;
            SEG_3:     value_o = 4'h3;
            SEG_4:     value_o = 4'h4;
            SEG_5:     value_o = 4'h5;
            SEG_6:     value_o = 4'h6;
            SEG_7:     value_o = 4'h7;
            SEG_8:     value_o = 4'h8;
            SEG_9:     value_o = 4'h9;
            SEG_A:     value_o = 4'hA;
            SEG_B:     value_o = 4'hB;
            SEG_C:     value_o = 4'hC;
            SEG_D:     value_o = 4'hD;
            SEG_E:     value_o = 4'hE;
            SEG_F:     value_o = 4'hF;
            SEG_BLANK: begin
                is_blank_o = 1'b1;
                is_valid_o = 1'b0;
            end
            default:   is_valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_display_capture.sv
// seg_display_capture
//   Receive side of a multiplexed 4-digit 7-segment display. Synchronises
//   the anode/segment lines, waits for each digit slot to settle, decodes
//   the glyph and publishes a coherent 4-digit frame once all positions
//   have been captured.
//   Ports:
//     clk          system clock
//     rst          synchronous active-low reset
//     led_seg[6:0] segment lines (bit0=a .. bit6=g)
//     AN[3:0]      anode lines, AN[i] selects digit i (0 = rightmost)
//     digits[15:0] captured frame, digits[4i+3:4i] = digit i
//     digit_blank  bit i set when digit i was blank in the frame
//     frame_valid  one-cycle pulse when digits/digit_blank update
//     bad_pattern  sticky flag for an unrecognised lit pattern
//     stale        no frame completed within TIMEOUT_CYCLES
//     err_count    (SEG_CAPTURE_ERR_COUNT_EN only) saturating count of
//                  unrecognised-pattern samples
module seg_display_capture
    import seg_capture_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              led_seg,
    input  logic [NUM_DIGITS-1:0]   AN,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic                    frame_valid,
    output logic                    bad_pattern,
    output logic                    stale
`ifdef SEG_CAPTURE_ERR_COUNT_EN
    ,
    output logic [7:0]              err_count
`endif
);

    localparam logic [7:0]  SETTLE_MAX = 8'(SETTLE_CYCLES);
    localparam logic [7:0]  STROBE_AT  = 8'(SETTLE_CYCLES - 2);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);

    logic [NUM_DIGITS-1:0]   an_s1_q, an_s2_q;
    logic [6:0]              seg_s1_q, seg_s2_q;
    logic [NUM_DIGITS+6:0]   prev_q;
    logic [7:0]              stab_q, stab_d;
    logic [4*NUM_DIGITS-1:0] shadow_q;
    logic [NUM_DIGITS-1:0]   blank_sh_q;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [15:0]             to_q;
    frame_state_e            state_q;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   digit_blank_q;
    logic                    frame_valid_q, bad_q, stale_q;

    logic [NUM_DIGITS-1:0]   an_act;
    logic [6:0]              seg_act;
    logic                    changed, strobe, one_hot;
    logic [1:0]              idx;
    logic [3:0]              dec_val;
    logic                    dec_blank, dec_valid;
    logic                    accept, bad_sample, publish_go;

    // Polarity is normalised after the synchroniser so 1 = active inside.
    assign an_act  = AN_ACTIVE_LOW  ? ~an_s2_q  : an_s2_q;
    assign seg_act = SEG_ACTIVE_LOW ? ~seg_s2_q : seg_s2_q;

    seg7_pattern_decode u_decode (
        .pattern_i  (seg_act),
        .value_o    (dec_val),
        .is_blank_o (dec_blank),
        .is_valid_o (dec_valid)
    );

    always_comb begin
        changed = ({an_s2_q, seg_s2_q} != prev_q);
        stab_d  = stab_q;
        if (changed) begin
            stab_d = '0;
        end else if (stab_q != SETTLE_MAX) begin
            stab_d = stab_q + 8'd1;
        end
        // Single strobe per stable window: the cycle the count moves to SETTLE-1.
        strobe = !changed && (stab_q == STROBE_AT);
    end

    always_comb begin
        one_hot = 1'b1;
        idx     = 2'd0;
        case (an_act)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: one_hot = 1'b0;
        endcase
    end

    assign accept     = strobe && one_hot && (dec_valid || dec_blank);
    assign bad_sample = strobe && one_hot && !dec_valid && !dec_blank;
    assign publish_go = (state_q == COLLECT) && (seen_q == '1);

    // A sample landing on the publish edge is merged after the clear.
    always_comb begin
        seen_d = publish_go ? '0 : seen_q;
        if (accept) begin
            seen_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            an_s1_q       <= '0;
            an_s2_q       <= '0;
            seg_s1_q      <= '0;
            seg_s2_q      <= '0;
            prev_q        <= '0;
            stab_q        <= '0;
            shadow_q      <= '0;
            blank_sh_q    <= '0;
            seen_q        <= '0;
            to_q          <= '0;
            state_q       <= COLLECT;
            digits_q      <= '0;
            digit_blank_q <= '0;
            frame_valid_q <= 1'b0;
            bad_q         <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            an_s1_q  <= AN;
            an_s2_q  <= an_s1_q;
            seg_s1_q <= led_seg;
            seg_s2_q <= seg_s1_q;
            prev_q   <= {an_s2_q, seg_s2_q};
            stab_q   <= stab_d;
            seen_q   <= seen_d;

            if (accept) begin
                shadow_q[{idx, 2'b00} +: 4] <= dec_blank ? 4'h0 : dec_val;
                blank_sh_q[idx]             <= dec_blank;
            end

            if (bad_sample) begin
                bad_q <= 1'b1;
            end

            case (state_q)
                COLLECT: begin
                    if (publish_go) begin
                        state_q       <= PUBLISH;
                        digits_q      <= shadow_q;
                        digit_blank_q <= blank_sh_q;
                        frame_valid_q <= 1'b1;
                        to_q          <= '0;
                        stale_q       <= 1'b0;
                    end else begin
                        frame_valid_q <= 1'b0;
                        if (to_q == TO_LAST) begin
                            stale_q <= 1'b1;
                        end else begin
                            to_q <= to_q + 16'd1;
                        end
                    end
                end
                PUBLISH: begin
                    state_q       <= COLLECT;
                    frame_valid_q <= 1'b0;
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

`ifdef SEG_CAPTURE_ERR_COUNT_EN
    logic [7:0] err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= '0;
        end else if (bad_sample && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_count = err_q;
`endif

    assign digits      = digits_q;
    assign digit_blank = digit_blank_q;
    assign frame_valid = frame_valid_q;
    assign bad_pattern = bad_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg_display_capture.sv
// tb_seg_display_capture
//   Directed bench for seg_display_capture with default parameters.
//   Frames are driven as active-low scans (digit 0 first); a monitor
//   counts frame_valid pulses and records their cycle and stale level.
module tb_seg_display_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  led_seg = 7'h7F;
    logic [3:0]  AN = 4'hF;
    logic [15:0] digits;
    logic [3:0]  digit_blank;
    logic        frame_valid, bad_pattern, stale;
`ifdef SEG_CAPTURE_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    seg_display_capture #(
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (1024),
        .AN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .led_seg     (led_seg),
        .AN          (AN),
        .digits      (digits),
        .digit_blank (digit_blank),
        .frame_valid (frame_valid),
        .bad_pattern (bad_pattern),
        .stale       (stale)
`ifdef SEG_CAPTURE_ERR_COUNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int fv_count = 0;
    int fv_cyc   = 0;
    logic fv_stale = 1'b0;
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fv_count = fv_count + 1;
            fv_cyc   = cyc;
            fv_stale = stale;
        end
    end

    int errors = 0;
    int checks = 0;
    int last_drive = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Codes 0..15 = hex glyphs, 16 = blank, 17 = unrecognised (b,d,f lit)
    function automatic logic [6:0] seg_hi(input int code);
        case (code)
            0:  return 7'h3F;  1:  return 7'h06;  2:  return 7'h5B;  3:  return 7'h4F;
            4:  return 7'h66;  5:  return 7'h6D;  6:  return 7'h7D;  7:  return 7'h07;
            8:  return 7'h7F;  9:  return 7'h6F;  10: return 7'h77;  11: return 7'h7C;
            12: return 7'h39;  13: return 7'h5E;  14: return 7'h79;  15: return 7'h71;
            17: return 7'b0101010;
            default: return 7'h00;
        endcase
    endfunction

    // Drive one digit slot for n cycles, starting just after a rising edge.
    task automatic slot(input int idx, input int code, input int n);
        logic [3:0] one;
        @(posedge clk);
        #1;
        one = 4'b0001 << idx;
        AN = ~one;
        led_seg = ~seg_hi(code);
        last_drive = cyc;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic scan(input int c3, input int c2, input int c1, input int c0);
        slot(0, c0, 20);
        slot(1, c1, 20);
        slot(2, c2, 20);
        slot(3, c3, 20);
    endtask

    typedef struct {
        int          c3, c2, c1, c0;
        logic [15:0] exp_d;
        logic [3:0]  exp_b;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int fv0;
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fv0;

        vecs[0] = '{c3: 1,  c2: 2,  c1: 5,  c0: 9,  exp_d: 16'h1259, exp_b: 4'b0000};
        vecs[1] = '{c3: 10, c2: 11, c1: 12, c0: 13, exp_d: 16'hABCD, exp_b: 4'b0000};
        vecs[2] = '{c3: 14, c2: 15, c1: 0,  c0: 8,  exp_d: 16'hEF08, exp_b: 4'b0000};
        vecs[3] = '{c3: 16, c2: 3,  c1: 4,  c0: 7,  exp_d: 16'h0347, exp_b: 4'b1000};
        vecs[4] = '{c3: 6,  c2: 16, c1: 16, c0: 0,  exp_d: 16'h6000, exp_b: 4'b0110};

        // Reset with random pins
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            AN = 4'($urandom);
            led_seg = 7'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("rst_outputs", {digits, digit_blank, frame_valid, bad_pattern, stale}, '0);
        end
        @(posedge clk);
        #1;
        AN = 4'hF;
        led_seg = 7'h7F;
        rst = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("post_rst_outputs", {digits, digit_blank, frame_valid, bad_pattern, stale}, '0);
        check("post_rst_frames", fv_count, 0);

        // Table-driven clean scans
        for (int v = 0; v < 5; v++) begin
            fv0 = fv_count;
            scan(vecs[v].c3, vecs[v].c2, vecs[v].c1, vecs[v].c0);
            @(negedge clk);
            check($sformatf("scan%0d_frames", v), fv_count - fv0, 1);
            check($sformatf("scan%0d_latency", v), fv_cyc - last_drive, 7);
            check($sformatf("scan%0d_digits", v), digits, vecs[v].exp_d);
            check($sformatf("scan%0d_blank", v), digit_blank, vecs[v].exp_b);
        end
        check("no_bad_yet", bad_pattern, 0);

        // Glitch: a 2-cycle "8" ends digit 1's slot and must not be sampled
        fv0 = fv_count;
        slot(0, 9, 20);
        slot(1, 5, 18);
        slot(1, 8, 2);
        slot(2, 2, 20);
        slot(3, 1, 20);
        @(negedge clk);
        check("glitch_frames", fv_count - fv0, 1);
        check("glitch_digits", digits, 16'h1259);
        check("glitch_blank", digit_blank, 4'b0000);

        // Unrecognised pattern on digit 2 blocks the frame until it is valid
        fv0 = fv_count;
        slot(0, 9, 20);
        slot(1, 5, 20);
        slot(2, 17, 20);
        slot(3, 1, 20);
        @(negedge clk);
        check("bad_set", bad_pattern, 1);
        check("bad_no_frame", fv_count - fv0, 0);
        slot(2, 2, 20);
        @(negedge clk);
        check("bad_recover_frames", fv_count - fv0, 1);
        check("bad_recover_digits", digits, 16'h1259);
        check("bad_sticky", bad_pattern, 1);
`ifdef SEG_CAPTURE_ERR_COUNT_EN
        check("err_count", err_count, 1);
`endif

        // Two anodes at once: ignored, so the frame times out
        fv0 = fv_count;
        @(posedge clk);
        #1;
        AN = 4'b1100;
        led_seg = ~seg_hi(3);
        repeat (900) @(posedge clk);
        @(negedge clk);
        check("stale_early", stale, 0);
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("stale_set", stale, 1);
        check("multi_no_frame", fv_count - fv0, 0);
        scan(4, 3, 2, 1);
        @(negedge clk);
        check("stale_frames", fv_count - fv0, 1);
        check("stale_clear_at_fv", fv_stale, 0);
        check("stale_digits", digits, 16'h4321);
        check("stale_after", stale, 0);

        // Reset mid-frame discards the partial frame
        slot(0, 1, 20);
        slot(1, 2, 20);
        @(posedge clk);
        #1;
        rst = 1'b0;
        AN = 4'hF;
        led_seg = 7'h7F;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", {digits, digit_blank, frame_valid, bad_pattern, stale}, '0);
        fv0 = fv_count;
        slot(2, 3, 20);
        slot(3, 4, 20);
        @(negedge clk);
        check("midrst_no_frame", fv_count - fv0, 0);
        // Digits 2,3 are already held, so this scan completes at digit 1
        scan(9, 8, 7, 6);
        @(negedge clk);
        check("midrst_frames", fv_count - fv0, 1);
        check("midrst_digits", digits, 16'h4376);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
